// File: rtl/c5g_housekeeping_pio_pkg.sv
// Shared constants and FSM state type for the housekeeping select PIO.
// Imported by the guard timer and the top.
package c5g_housekeeping_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_SET    = 3'd2;
  localparam logic [2:0] ADDR_CLR    = 3'd3;
  localparam logic [2:0] ADDR_GUARD  = 3'd4;

  localparam int ST_BUSY    = 0;
  localparam int ST_ERR     = 1;
  localparam int ST_OUT_LSB = 16;

  typedef enum logic {
    S_IDLE,
    S_BREAK
  } state_e;

endpackage

// File: rtl/c5g_housekeeping_guard_timer.sv
// Loadable down-counter timing the break interval.
// Load wins over decrement; the count never wraps below zero.
module c5g_housekeeping_guard_timer
  import c5g_housekeeping_pio_pkg::*;
#(
  parameter int GUARD_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [GUARD_W-1:0] load_val,
  input  logic               dec,
  output logic [GUARD_W-1:0] value,
  output logic               zero
);

  logic [GUARD_W-1:0] cnt_d;
  logic [GUARD_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - GUARD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/c5g_housekeeping_select_pio.sv
// Avalon-MM select register with break-before-make sequencing:
// out_port passes through IDLE_VALUE for `guard` cycles on every change.
module c5g_housekeeping_select_pio
  import c5g_housekeeping_pio_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int RESET_VALUE   = 0,
  parameter int IDLE_VALUE    = 0,
  parameter int GUARD_W       = 8,
  parameter int GUARD_DEFAULT = 8,
  parameter int ONEHOT        = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             busy
);

  localparam logic [WIDTH-1:0]   RST_V  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0]   IDLE_V = WIDTH'(IDLE_VALUE);
  localparam logic [GUARD_W-1:0] GRD_V  = GUARD_W'(GUARD_DEFAULT);

  logic [WIDTH-1:0]   req_d, req_q;
  logic [WIDTH-1:0]   out_d, out_q;
  logic [GUARD_W-1:0] guard_d, guard_q;
  logic               err_d, err_q;
  state_e             state_d, state_q;

  logic               wr;
  logic [WIDTH-1:0]   wd;
  logic [WIDTH-1:0]   cand;
  logic               cand_wr;
  logic               reject;
  logic               tmr_load;
  logic               tmr_dec;
  logic [GUARD_W-1:0] tmr_value;
  logic               tmr_zero;
  logic               unused;

  assign wr     = chipselect & ~write_n;
  assign wd     = writedata[WIDTH-1:0];
  assign unused = ^{writedata, tmr_value};

  always_comb begin
    cand    = req_q;
    cand_wr = 1'b0;
    if (wr) begin
      case (address)
        ADDR_DATA: begin cand = wd;            cand_wr = 1'b1; end
        ADDR_SET:  begin cand = req_q | wd;    cand_wr = 1'b1; end
        ADDR_CLR:  begin cand = req_q & ~wd;   cand_wr = 1'b1; end
        default:   ;
      endcase
    end
  end

  // More than one bit set <=> clearing the lowest set bit leaves a residue.
  assign reject = cand_wr && (ONEHOT != 0) &&
                  ((cand & (cand - WIDTH'(1))) != '0);

  always_comb begin
    req_d   = (cand_wr && !reject) ? cand : req_q;
    guard_d = guard_q;
    err_d   = err_q;
    if (wr && (address == ADDR_GUARD)) guard_d = writedata[GUARD_W-1:0];
    if (wr && (address == ADDR_STATUS) && writedata[ST_ERR]) err_d = 1'b0;
    if (reject) err_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_q != out_q) begin
          if (guard_q == '0) begin
            out_d = req_q;
          end else begin
            out_d    = IDLE_V;
            tmr_load = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (tmr_zero) begin
          out_d   = req_q;
          state_d = S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= RST_V;
      out_q   <= RST_V;
      guard_q <= GRD_V;
      err_q   <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      req_q   <= req_d;
      out_q   <= out_d;
      guard_q <= guard_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  c5g_housekeeping_guard_timer #(
    .GUARD_W (GUARD_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (guard_q - GUARD_W'(1)),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  assign out_port = out_q;
  assign busy     = (state_q == S_BREAK) | (req_q != out_q);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = req_q;
      ADDR_STATUS: begin
        readdata[ST_BUSY]            = busy;
        readdata[ST_ERR]             = err_q;
        readdata[ST_OUT_LSB +: WIDTH] = out_q;
      end
      ADDR_GUARD:  readdata[GUARD_W-1:0] = guard_q;
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_c5g_housekeeping_select_pio.sv
// Bench for the select PIO: three builds (plain, one-hot, idle=3/reset=1)
// share one bus and are compared each cycle against a timeline model.
module tb_c5g_housekeeping_select_pio;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rd0, rd1, rd2;
  logic [1:0]  out0, out1, out2;
  logic        busy0, busy1, busy2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  int m_req[3], m_out[3], m_guard[3], m_err[3], m_left[3];

  int e2_0[6] = '{0, 0, 0, 0, 2, 2};
  int e2_b[6] = '{1, 1, 1, 1, 0, 0};
  int e2_2[6] = '{1, 3, 3, 3, 2, 2};
  int e4_0[8] = '{0, 0, 0, 0, 0, 0, 2, 2};
  int e4_2[8] = '{0, 3, 3, 3, 3, 3, 2, 2};

  c5g_housekeeping_select_pio u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0),
    .out_port(out0), .busy(busy0)
  );

  c5g_housekeeping_select_pio #(.ONEHOT(1)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1),
    .out_port(out1), .busy(busy1)
  );

  c5g_housekeeping_select_pio #(.IDLE_VALUE(3), .RESET_VALUE(1)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2),
    .out_port(out2), .busy(busy2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int p_idle(int k);
    return (k == 2) ? 3 : 0;
  endfunction

  function automatic int p_rst(int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int m_busy(int k);
    return ((m_left[k] > 0) || (m_req[k] != m_out[k])) ? 1 : 0;
  endfunction

  function automatic int m_rd(int k, logic [2:0] a);
    case (a)
      3'd0:    return m_req[k];
      3'd1:    return (m_out[k] << 16) | (m_err[k] << 1) | m_busy(k);
      3'd4:    return m_guard[k];
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // m_left = break cycles still to be shown; 0 means not in a break.
  always @(posedge clk) begin : mdl
    int nreq, nerr, ng, cand;
    bit cw;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_req[k]   = p_rst(k);
        m_out[k]   = p_rst(k);
        m_guard[k] = 8;
        m_err[k]   = 0;
        m_left[k]  = 0;
      end else begin
        nreq = m_req[k];
        nerr = m_err[k];
        ng   = m_guard[k];
        cand = 0;
        cw   = 0;
        if (chipselect && !write_n) begin
          case (address)
            3'd0: begin cand = int'(writedata) & 3; cw = 1; end
            3'd2: begin cand = (m_req[k] | int'(writedata)) & 3; cw = 1; end
            3'd3: begin cand = m_req[k] & ~int'(writedata) & 3; cw = 1; end
            3'd1: if (writedata[1]) nerr = 0;
            3'd4: ng = int'(writedata) & 255;
            default: ;
          endcase
        end
        if (cw) begin
          if (k == 1 && $countones(cand) > 1) nerr = 1;
          else nreq = cand;
        end
        if (m_left[k] == 0) begin
          if (m_req[k] != m_out[k]) begin
            if (m_guard[k] == 0) m_out[k] = m_req[k];
            else begin
              m_out[k]  = p_idle(k);
              m_left[k] = m_guard[k];
            end
          end
        end else begin
          m_left[k]--;
          if (m_left[k] == 0) m_out[k] = m_req[k];
        end
        m_req[k]   = nreq;
        m_err[k]   = nerr;
        m_guard[k] = ng;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0.out",  out0,  m_out[0]);
      chk("u1.out",  out1,  m_out[1]);
      chk("u2.out",  out2,  m_out[2]);
      chk("u0.busy", busy0, m_busy(0));
      chk("u1.busy", busy1, m_busy(1));
      chk("u2.busy", busy2, m_busy(2));
      chk("u0.rd",   rd0,   m_rd(0, address));
      chk("u1.rd",   rd1,   m_rd(1, address));
      chk("u2.rd",   rd2,   m_rd(2, address));
    end
  end

  task automatic cyc(input bit c, input bit w, input logic [2:0] a,
                     input logic [31:0] d);
    #1;
    chipselect = c;
    write_n    = !w;
    address    = a;
    writedata  = d;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1, 1, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1, 0, a, 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    chipselect = 0;
    write_n    = 1;
    address    = 0;
    writedata  = 0;
    reset      = 1;
    repeat (2) @(negedge clk);
    #1 reset = 0;
    chk_en = 1;
    @(negedge clk);

    rd(0);  chk("t1.data", rd0, 0);
    rd(1);  chk("t1.status", rd0, 0);
    chk("t1.status.u2", rd2, 32'h0001_0000);
    rd(4);  chk("t1.guard", rd0, 8);
    chk("t1.out", out0, 0);
    chk("t1.busy", busy0, 0);
    chk("t1.out.u2", out2, 1);
    for (int a = 5; a < 8; a++) begin
      rd(3'(a));
      chk("t1.rsvd", rd0, 0);
    end

    wr(4, 3);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) wr(0, 2);
      else idle();
      chk("t2.out.u0", out0, e2_0[i]);
      chk("t2.busy.u0", busy0, e2_b[i]);
      chk("t2.out.u2", out2, e2_2[i]);
    end

    wr(4, 0);
    wr(0, 1);
    chk("t3.hold.u2", out2, 2);
    idle();
    chk("t3.direct.u2", out2, 1);
    chk("t3.direct.u0", out0, 1);
    wr(2, 2);
    idle();
    chk("t3.set", out0, 3);
    rd(0);
    chk("t5.reject", rd1, 1);
    rd(1);
    chk("t5.err", rd1, 32'h0001_0002);
    wr(3, 1);
    idle();
    chk("t3.clr", out0, 2);
    chk("t5.clr.u1", out1, 0);
    wr(1, 2);
    rd(1);
    chk("t5.w1c", rd1, 0);
    wr(0, 2);
    rd(0);
    chk("t5.accept", rd1, 2);

    wr(0, 0);
    idle();
    idle();
    wr(4, 5);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) wr(0, 1);
      else if (i == 2) wr(0, 2);
      else idle();
      chk("t4.out.u0", out0, e4_0[i]);
      chk("t4.out.u2", out2, e4_2[i]);
    end

    wr(0, 1);
    idle();
    idle();
    chk("t6.inbrk.u2", out2, 3);
    #1;
    reset      = 1;
    chipselect = 0;
    @(negedge clk);
    chk("t6.out.u2", out2, 1);
    chk("t6.busy.u2", busy2, 0);
    chk("t6.out.u0", out0, 0);
    #1 reset = 0;
    rd(4);
    chk("t6.guard.u2", rd2, 8);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
